matrix_stream_loader: RTL and testbench
=======================================

// Module: matrix_stream_loader
//
// PURPOSE
//   Upstream stage of matrix_transpose. Collects a row-major stream of
//   WORD_LENGTH-bit elements into a registered MATRIX_SIZE x MATRIX_SIZE matrix.
//   Presents the full matrix as an unpacked 2-D array with a valid/ready
//   handshake. Output array A connects directly to matrix_transpose.A.
//   Framing errors (in_last in the wrong position) are flagged.
//
// PARAMETERS
//   MATRIX_SIZE   3   rows = cols of the square matrix (>=2)
//   WORD_LENGTH   8   bits per element
//
// PORTS
//   clk        in   1            rising-edge clock
//   rst_n      in   1            async active-low reset
//   in_data    in   WORD_LENGTH  element, row-major order
//   in_valid   in   1            in_data valid
//   in_ready   out  1            loader can accept an element
//   in_last    in   1            marks final element of a matrix
//   A          out  [WORD_LENGTH-1:0] [0:N-1][0:N-1]   assembled matrix, A[row][col]
//   A_valid    out  1            A holds a complete matrix
//   A_ready    in   1            consumer accepts A
//   frame_err  out  1            sticky framing error
//   err_clr    in   1            clears frame_err
//
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - state=LOAD; row=col=0; all A elements=0; A_valid=0; frame_err=0.
//   FSM, 2 states:
//     - LOAD: in_ready=1, A_valid=0.
//     - FULL: in_ready=0, A_valid=1.
//   Accept rule: an element is accepted on a clk edge where in_valid && in_ready.
//     - The accepted element is written to A[row][col].
//     - col increments. When col reaches N-1 it wraps to 0 and row increments.
//   Final element (row=N-1, col=N-1) accepted:
//     - Next state is FULL, so A_valid=1 one cycle after the final accept.
//     - If in_last=0 on the final element, frame_err is set. The matrix is still
//       delivered.
//   Early in_last (in_last=1 on a non-final element):
//     - The element is written.
//     - frame_err is set.
//     - row and col return to 0, so the partial matrix is discarded.
//     - The FSM stays in LOAD.
//   FULL:
//     - A is held stable. No writes occur.
//     - On A_valid && A_ready: next state is LOAD, row=col=0, and A_valid drops the
//       next cycle.
//     - in_ready rises in that same next cycle. There is no same-cycle refill.
//   A while LOAD: registers hold old or partial data. Consumers sample A only
//     while A_valid=1.
//   Throughput: at most one matrix per N*N+1 cycles with continuous valid/ready.
//   frame_err:
//     - Sticky.
//     - err_clr=1 clears it the next cycle.
//     - If a set event and err_clr occur in the same cycle, set wins.
//   Bubbles: in_valid=0 cycles leave all state unchanged.
//   Counter widths: $clog2(MATRIX_SIZE), minimum 1 bit.
//   Reset mid-operation:
//     - Partial or FULL content is cleared to 0.
//     - A_valid drops immediately (asynchronously).
//     - The loader resumes in LOAD at (0,0).
//
// TESTING (N=3, W=8)
//   1. Stream 1..9, in_last on the 9th element, A_ready=1:
//      -> A_valid 1 cycle after the 9th accept.
//      -> A = {{1,2,3},{4,5,6},{7,8,9}}; transpose stage yields {{1,4,7},{2,5,8},{3,6,9}}.
//   2. Full matrix, A_ready=0 for 5 cycles, in_valid held 1:
//      -> in_ready=0 and A stable for all 5 cycles.
//      -> After A_ready, the next accept lands at A[0][0].
//   3. in_last on the 4th element, then stream 10..18 with correct framing:
//      -> frame_err=1.
//      -> Delivered A = {{10,11,12},{13,14,15},{16,17,18}}.
//   4. 9 elements with in_last=0:
//      -> Matrix delivered and frame_err=1.
//      -> err_clr pulse clears frame_err to 0.
//   5. Random in_valid/A_ready bubbles over 50 matrices:
//      -> Every delivered matrix equals the scoreboard.
//      -> No element is lost or duplicated.
//   6. rst_n low after 5 elements:
//      -> A all 0 and A_valid=0 immediately.
//      -> The next stream loads from (0,0).

Source files
------------

// File: rtl/matrix_stream_loader.sv
// Collects a row-major element stream into a registered square matrix and
// hands it downstream with a valid/ready handshake; flags in_last misplacement.
module matrix_stream_loader #(
  parameter int MATRIX_SIZE = 3,
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WORD_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  output logic [WORD_LENGTH-1:0] A [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1],
  output logic                   A_valid,
  input  logic                   A_ready,
  output logic                   frame_err,
  input  logic                   err_clr
);

  localparam int CW = (MATRIX_SIZE > 2) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MATRIX_SIZE - 1);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]             r_state;
  logic [CW-1:0]          r_row;
  logic [CW-1:0]          r_col;
  logic [WORD_LENGTH-1:0] r_mat [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1];
  logic                   r_frame_err;

  logic w_accept;
  logic w_final;
  logic w_frame_bad;

  assign w_accept    = in_valid && (r_state == ST_LOAD);
  assign w_final     = (r_row == LAST_IDX) && (r_col == LAST_IDX);
  assign w_frame_bad = w_accept && (w_final ? !in_last : in_last);

  // An early in_last rewinds to (0,0), dropping the partial matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_row   <= '0;
      r_col   <= '0;
    end else if (r_state == ST_LOAD) begin
      if (w_accept) begin
        if (w_final) begin
          r_state <= ST_FULL;
          r_row   <= '0;
          r_col   <= '0;
        end else if (in_last) begin
          r_row <= '0;
          r_col <= '0;
        end else if (r_col == LAST_IDX) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end else if (A_ready) begin
      r_state <= ST_LOAD;
      r_row   <= '0;
      r_col   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MATRIX_SIZE; r++) begin
        for (int c = 0; c < MATRIX_SIZE; c++) begin
          r_mat[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      r_mat[r_row][r_col] <= in_data;
    end
  end

  // A set event in the same cycle as err_clr keeps the flag raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else if (w_frame_bad) begin
      r_frame_err <= 1'b1;
    end else if (err_clr) begin
      r_frame_err <= 1'b0;
    end
  end

  assign in_ready  = (r_state == ST_LOAD);
  assign A_valid   = (r_state == ST_FULL);
  assign A         = r_mat;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed and randomized checks of matrix_stream_loader (N=3, W=8) against a
// bench-side matrix model and a scoreboard of expected matrices.
module tb_matrix_stream_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic [7:0] A [0:2][0:2];
  logic       A_valid;
  logic       A_ready;
  logic       frame_err;
  logic       err_clr;

  int total = 0;
  int bad   = 0;

  logic [71:0] expQ [$];
  logic [71:0] modelMat;
  int          modelIdx = 0;
  logic        expErr = 1'b0;
  int          pushed = 0;
  int          delivered = 0;
  logic        randDone;

  matrix_stream_loader #(.MATRIX_SIZE(3), .WORD_LENGTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .A(A), .A_valid(A_valid),
    .A_ready(A_ready), .frame_err(frame_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] packA();
    logic [71:0] m;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m[(r*3+c)*8 +: 8] = A[r][c];
    return m;
  endfunction

  function automatic logic [71:0] mk(input int start);
    logic [71:0] m;
    for (int i = 0; i < 9; i++) m[i*8 +: 8] = 8'(start + i);
    return m;
  endfunction

  function automatic logic [71:0] transposeOf(input logic [71:0] m);
    logic [71:0] t;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        t[(c*3+r)*8 +: 8] = m[(r*3+c)*8 +: 8];
    return t;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one element until accepted, then advances the reference model.
  task automatic sendElem(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 72'(in_ready), 72'(1));
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    modelMat[modelIdx*8 +: 8] = d;
    if (modelIdx == 8) begin
      expQ.push_back(modelMat);
      pushed++;
      if (!l) expErr = 1'b1;
      else if (err_clr) expErr = 1'b0;
      modelIdx = 0;
    end else if (l) begin
      expErr   = 1'b1;
      modelIdx = 0;
    end else begin
      if (err_clr) expErr = 1'b0;
      modelIdx++;
    end
  endtask

  task automatic sendMatrix(input int start, input logic goodFrame);
    for (int i = 0; i < 9; i++)
      sendElem(8'(start + i), (i == 8) ? goodFrame : 1'b0);
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    expErr  = 1'b0;
  endtask

  // Scoreboard: every handshake at the upcoming edge must match the oldest push.
  always @(negedge clk) begin
    if (rst_n && A_valid && A_ready) begin
      if (expQ.size() == 0) begin
        check("unexpected_matrix", 72'(1), 72'(0));
      end else begin
        check("scoreboard_matrix", packA(), expQ.pop_front());
        delivered++;
      end
    end
  end

  initial begin
    logic [71:0] held;
    int waitN;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    A_ready = 1'b1; err_clr = 1'b0; randDone = 1'b0; modelMat = '0;

    #12;
    check("reset_A", packA(), 72'(0));
    check("reset_A_valid", 72'(A_valid), 72'(0));
    check("reset_in_ready", 72'(in_ready), 72'(1));
    check("reset_frame_err", 72'(frame_err), 72'(0));
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] test 1: basic stream");
    for (int i = 0; i < 8; i++) sendElem(8'(i + 1), 1'b0);
    @(negedge clk);
    check("t1_no_valid_before_last", 72'(A_valid), 72'(0));
    tick();
    sendElem(8'd9, 1'b1);
    @(negedge clk);
    check("t1_A_valid", 72'(A_valid), 72'(1));
    check("t1_in_ready_low", 72'(in_ready), 72'(0));
    check("t1_A", packA(), mk(1));
    check("t1_transpose", transposeOf(packA()),
          {8'd9, 8'd6, 8'd3, 8'd8, 8'd5, 8'd2, 8'd7, 8'd4, 8'd1});
    check("t1_frame_err", 72'(frame_err), 72'(0));
    tick();
    @(negedge clk);
    check("t1_A_valid_drop", 72'(A_valid), 72'(0));
    check("t1_in_ready_back", 72'(in_ready), 72'(1));
    tick();

    $display("[TB] test 2: backpressure");
    A_ready = 1'b0;
    sendMatrix(20, 1'b1);
    in_valid = 1'b1; in_data = 8'd99; in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_in_ready_held", 72'(in_ready), 72'(0));
      check("t2_A_stable", packA(), mk(20));
      tick();
    end
    A_ready = 1'b1;
    sendElem(8'd99, 1'b0);
    @(negedge clk);
    held = packA();
    check("t2_refill_at_00", 72'(held[7:0]), 72'(99));
    check("t2_rest_untouched", 72'(held[71:8]), 72'(mk(20) >> 8));
    tick();
    for (int i = 1; i < 9; i++) sendElem(8'(100 + i), (i == 8));

    $display("[TB] test 3: early in_last");
    for (int i = 0; i < 4; i++) sendElem(8'(i + 1), (i == 3));
    @(negedge clk);
    check("t3_frame_err", 72'(frame_err), 72'(expErr));
    check("t3_frame_err_set", 72'(frame_err), 72'(1));
    tick();
    for (int i = 0; i < 8; i++) sendElem(8'(10 + i), 1'b0);
    sendElem(8'd18, 1'b1);
    @(negedge clk);
    check("t3_A", packA(), mk(10));
    check("t3_err_sticky", 72'(frame_err), 72'(1));
    tick();
    pulseErrClr();
    @(negedge clk);
    check("t3_err_cleared", 72'(frame_err), 72'(0));
    tick();

    $display("[TB] test 4: missing in_last");
    sendMatrix(30, 1'b0);
    @(negedge clk);
    check("t4_A_valid", 72'(A_valid), 72'(1));
    check("t4_A", packA(), mk(30));
    check("t4_frame_err", 72'(frame_err), 72'(1));
    tick();
    pulseErrClr();
    @(negedge clk);
    check("t4_err_cleared", 72'(frame_err), 72'(0));
    tick();
    err_clr = 1'b1;
    sendElem(8'd77, 1'b1);
    err_clr = 1'b0;
    @(negedge clk);
    check("t4_set_beats_clear", 72'(frame_err), 72'(1));
    tick();
    pulseErrClr();

    $display("[TB] test 5: random bubbles");
    fork
      begin
        for (int m = 0; m < 50; m++) begin
          for (int i = 0; i < 9; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            sendElem(8'($urandom_range(0, 255)), (i == 8));
          end
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          tick();
          A_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    A_ready = 1'b1;
    waitN = 0;
    while (expQ.size() != 0 && waitN < 100) begin
      tick();
      waitN++;
    end
    check("t5_queue_drained", 72'(expQ.size()), 72'(0));
    check("t5_no_loss_dup", 72'(delivered), 72'(pushed));
    check("t5_frame_err", 72'(frame_err), 72'(0));

    $display("[TB] test 6: reset mid-stream");
    for (int i = 0; i < 5; i++) sendElem(8'(200 + i), 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_A_zero", packA(), 72'(0));
    check("t6_A_valid", 72'(A_valid), 72'(0));
    modelIdx = 0;
    tick();
    rst_n = 1'b1;
    tick();
    sendMatrix(50, 1'b1);
    @(negedge clk);
    check("t6_reload_A", packA(), mk(50));
    tick();
    A_ready = 1'b0;
    sendMatrix(60, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_full_A_valid_async", 72'(A_valid), 72'(0));
    check("t6_full_A_zero", packA(), 72'(0));
    void'(expQ.pop_back());
    pushed--;
    modelIdx = 0;
    tick();
    rst_n = 1'b1;
    A_ready = 1'b1;
    tick();
    sendMatrix(70, 1'b1);
    @(negedge clk);
    check("t6_after_full_reset", packA(), mk(70));
    tick();
    tick();
    check("t6_queue_empty", 72'(expQ.size()), 72'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
